// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: sole writer of the register file write port.
// Merges the in-order pipeline writeback (always accepted, highest priority)
// with buffered multi-cycle unit results, and keeps a busy scoreboard and a
// starvation-driven stall request for the hazard unit.
module rf_wb_arbiter #(
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 wb_valid,
    input  logic [4:0]                           wb_addr,
    input  logic [31:0]                          wb_data,
    input  logic                                 mc_valid,
    output logic                                 mc_ready,
    input  logic [4:0]                           mc_addr,
    input  logic [31:0]                          mc_data,
    input  logic                                 mc_issue,
    input  logic [4:0]                           mc_issue_addr,
    output logic [4:0]                           RdAddr,
    output logic [31:0]                          RdData,
    output logic                                 RegWrite,
    output logic [31:0]                          busy,
    output logic                                 stall_req,
    output logic [$clog2(FIFO_DEPTH):0]          fifo_count
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);

    // FIFO storage and bookkeeping
    logic [4:0]        r_fifo_addr [FIFO_DEPTH];
    logic [31:0]       r_fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    // Write port, scoreboard and starvation state
    logic [4:0]        r_rd_addr;
    logic [31:0]       r_rd_data;
    logic              r_reg_write;
    logic [31:0]       r_busy;
    logic [STV_W-1:0]  r_starve;
    logic              r_stall;

    // Combinational decisions
    logic              w_ready;
    logic              w_push;
    logic              w_wb_win;
    logic              w_fifo_empty;
    logic              w_pop;
    logic [4:0]        w_head_addr;
    logic [31:0]       w_head_data;
    logic [CNT_W-1:0]  w_count_nxt;
    logic [31:0]       w_busy_nxt;
    logic [STV_W-1:0]  w_starve_nxt;

    assign w_fifo_empty = (r_count == '0);
    assign w_head_addr  = r_fifo_addr[r_rd_ptr];
    assign w_head_data  = r_fifo_data[r_rd_ptr];

    // Handshake and arbitration: wb to a real register always wins the port
    always_comb begin
        w_ready  = !rst && (r_count < CNT_W'(FIFO_DEPTH));
        w_push   = mc_valid && w_ready;
        w_wb_win = wb_valid && (wb_addr != 5'd0);
        w_pop    = !w_wb_win && !w_fifo_empty;
    end

    // Occupancy update; simultaneous push and pop leaves it unchanged
    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + CNT_W'(1);
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - CNT_W'(1);
        end
    end

    // Scoreboard update: clear on issue of the head, set on dispatch (set wins)
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_pop) begin
            w_busy_nxt[w_head_addr] = 1'b0;
        end
        if (mc_issue && (mc_issue_addr != 5'd0)) begin
            w_busy_nxt[mc_issue_addr] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    // Starvation counter: counts cycles the queued head loses to wb, saturating
    always_comb begin
        w_starve_nxt = '0;
        if (!w_fifo_empty && w_wb_win) begin
            if (r_starve == STV_W'(STARVE_LIMIT)) begin
                w_starve_nxt = r_starve;
            end else begin
                w_starve_nxt = r_starve + STV_W'(1);
            end
        end
    end

    // FIFO payload storage; contents are don't-care while the slot is empty
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= mc_addr;
            r_fifo_data[r_wr_ptr] <= mc_data;
        end
    end

    // FIFO pointers and count
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= w_count_nxt;
        end
    end

    // Registered RF write port; address/data hold when nothing is issued
    always_ff @(posedge clk) begin
        if (rst) begin
            r_reg_write <= 1'b0;
            r_rd_addr   <= 5'd0;
            r_rd_data   <= 32'd0;
        end else if (w_wb_win) begin
            r_reg_write <= 1'b1;
            r_rd_addr   <= wb_addr;
            r_rd_data   <= wb_data;
        end else if (w_pop) begin
            r_reg_write <= (w_head_addr != 5'd0);
            r_rd_addr   <= w_head_addr;
            r_rd_data   <= w_head_data;
        end else begin
            r_reg_write <= 1'b0;
        end
    end

    // Scoreboard, starvation counter and stall request
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy   <= '0;
            r_starve <= '0;
            r_stall  <= 1'b0;
        end else begin
            r_busy   <= w_busy_nxt;
            r_starve <= w_starve_nxt;
            r_stall  <= (r_starve == STV_W'(STARVE_LIMIT));
        end
    end

    assign mc_ready   = w_ready;
    assign RdAddr     = r_rd_addr;
    assign RdData     = r_rd_data;
    assign RegWrite   = r_reg_write;
    assign busy       = r_busy;
    assign stall_req  = r_stall;
    assign fifo_count = r_count;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: a vector table for single-cycle behaviour
// plus hand-written sequences for full FIFO, starvation and reset corners.
module tb_rf_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        mc_valid;
    logic        mc_ready;
    logic [4:0]  mc_addr;
    logic [31:0] mc_data;
    logic        mc_issue;
    logic [4:0]  mc_issue_addr;
    logic [4:0]  RdAddr;
    logic [31:0] RdData;
    logic        RegWrite;
    logic [31:0] busy;
    logic        stall_req;
    logic [2:0]  fifo_count;

    int n_tests = 0;
    int n_fail  = 0;

    rf_wb_arbiter #(.FIFO_DEPTH(4), .STARVE_LIMIT(3)) dut (
        .clk           (clk),
        .rst           (rst),
        .wb_valid      (wb_valid),
        .wb_addr       (wb_addr),
        .wb_data       (wb_data),
        .mc_valid      (mc_valid),
        .mc_ready      (mc_ready),
        .mc_addr       (mc_addr),
        .mc_data       (mc_data),
        .mc_issue      (mc_issue),
        .mc_issue_addr (mc_issue_addr),
        .RdAddr        (RdAddr),
        .RdData        (RdData),
        .RegWrite      (RegWrite),
        .busy          (busy),
        .stall_req     (stall_req),
        .fifo_count    (fifo_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wbv;
        logic [4:0]  wba;
        logic [31:0] wbd;
        logic        mcv;
        logic [4:0]  mca;
        logic [31:0] mcd;
        logic        iss;
        logic [4:0]  issa;
        logic        rw;
        logic [4:0]  ra;
        logic [31:0] rd;
        logic [31:0] bsy;
        logic [2:0]  cnt;
        logic        stall;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic wbv, input logic [4:0] wba, input logic [31:0] wbd,
                         input logic mcv, input logic [4:0] mca, input logic [31:0] mcd,
                         input logic iss, input logic [4:0] issa);
        wb_valid      = wbv;
        wb_addr       = wba;
        wb_data       = wbd;
        mc_valid      = mcv;
        mc_addr       = mca;
        mc_data       = mcd;
        mc_issue      = iss;
        mc_issue_addr = issa;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_write(input string nm, input logic [4:0] a, input logic [31:0] d);
        chk({nm, ".rw"}, 32'(RegWrite), 32'd1);
        chk({nm, ".addr"}, 32'(RdAddr), 32'(a));
        chk({nm, ".data"}, RdData, d);
    endtask

    initial begin
        // Table: inputs for one cycle, expected outputs right after its edge
        //           wbv wba   wbd           mcv mca   mcd           iss issa  rw ra    rd            busy          cnt stall
        tbl[0]  = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 5'd0, 0, 5'd0, 32'h0,        32'h0,        3'd0, 0};
        tbl[1]  = '{1, 5'd8, 32'hDEADBEEF, 0, 5'd0, 32'h0,        0, 5'd0, 1, 5'd8, 32'hDEADBEEF, 32'h0,        3'd0, 0};
        tbl[2]  = '{1, 5'd0, 32'h1234,     0, 5'd0, 32'h0,        0, 5'd0, 0, 5'd0, 32'h0,        32'h0,        3'd0, 0};
        tbl[3]  = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        1, 5'd5, 0, 5'd0, 32'h0,        32'h20,       3'd0, 0};
        tbl[4]  = '{0, 5'd0, 32'h0,        1, 5'd5, 32'h12345678, 0, 5'd0, 0, 5'd0, 32'h0,        32'h20,       3'd1, 0};
        tbl[5]  = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 5'd0, 1, 5'd5, 32'h12345678, 32'h0,        3'd0, 0};
        tbl[6]  = '{1, 5'd3, 32'h33,       0, 5'd0, 32'h0,        1, 5'd9, 1, 5'd3, 32'h33,       32'h200,      3'd0, 0};
        tbl[7]  = '{1, 5'd4, 32'h44,       1, 5'd9, 32'h99,       0, 5'd0, 1, 5'd4, 32'h44,       32'h200,      3'd1, 0};
        tbl[8]  = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        1, 5'd9, 1, 5'd9, 32'h99,       32'h200,      3'd0, 0};
        tbl[9]  = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 5'd0, 0, 5'd0, 32'h0,        32'h200,      3'd0, 0};
        tbl[10] = '{0, 5'd0, 32'h0,        1, 5'd9, 32'h9A,       0, 5'd0, 0, 5'd0, 32'h0,        32'h200,      3'd1, 0};
        tbl[11] = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 5'd0, 1, 5'd9, 32'h9A,       32'h0,        3'd0, 0};
        tbl[12] = '{0, 5'd0, 32'h0,        1, 5'd0, 32'hF0,       0, 5'd0, 0, 5'd0, 32'h0,        32'h0,        3'd1, 0};
        tbl[13] = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 5'd0, 0, 5'd0, 32'h0,        32'h0,        3'd0, 0};

        // Reset held two cycles with an offered result that must not enter
        rst = 1'b1;
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 32'h66, 1'b0, 5'd0);
        step();
        step();
        chk("rst.rw",    32'(RegWrite),   32'd0);
        chk("rst.ready", 32'(mc_ready),   32'd0);
        chk("rst.busy",  busy,            32'd0);
        chk("rst.cnt",   32'(fifo_count), 32'd0);
        chk("rst.stall", 32'(stall_req),  32'd0);
        rst = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        #1;
        chk("rel.ready", 32'(mc_ready),   32'd1);
        step();
        chk("rel.cnt",   32'(fifo_count), 32'd0);
        chk("rel.rw",    32'(RegWrite),   32'd0);

        // Table-driven single-cycle behaviour
        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].wbv, tbl[i].wba, tbl[i].wbd, tbl[i].mcv, tbl[i].mca, tbl[i].mcd,
                  tbl[i].iss, tbl[i].issa);
            step();
            chk($sformatf("v%0d.rw", i),    32'(RegWrite),   32'(tbl[i].rw));
            chk($sformatf("v%0d.busy", i),  busy,            tbl[i].bsy);
            chk($sformatf("v%0d.cnt", i),   32'(fifo_count), 32'(tbl[i].cnt));
            chk($sformatf("v%0d.stall", i), 32'(stall_req),  32'(tbl[i].stall));
            chk($sformatf("v%0d.ready", i), 32'(mc_ready),   32'd1);
            if (tbl[i].rw) begin
                chk($sformatf("v%0d.addr", i), 32'(RdAddr), 32'(tbl[i].ra));
                chk($sformatf("v%0d.data", i), RdData,      tbl[i].rd);
            end
        end

        // Full FIFO: fill under continuous wb, then a 5th offer is refused
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 5'd10, 32'hA0 + 32'(k), 1'b1, 5'(11 + k), 32'hB1 + 32'(k), 1'b0, 5'd0);
            step();
            chk_write($sformatf("full.wb%0d", k), 5'd10, 32'hA0 + 32'(k));
            chk($sformatf("full.cnt%0d", k), 32'(fifo_count), 32'(k + 1));
        end
        chk("full.ready", 32'(mc_ready), 32'd0);
        drive(1'b1, 5'd10, 32'hA4, 1'b1, 5'd15, 32'hB5, 1'b0, 5'd0);
        step();
        chk("full.cnt5", 32'(fifo_count), 32'd4);
        chk("full.stall", 32'(stall_req), 32'd1);
        // Drain: first pop cycle still offers the 5th entry, which must stay out
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 5'd0, 32'h0, (k == 0), 5'd15, 32'hB5, 1'b0, 5'd0);
            step();
            chk_write($sformatf("drain%0d", k), 5'(11 + k), 32'hB1 + 32'(k));
            chk($sformatf("drain%0d.cnt", k), 32'(fifo_count), 32'(3 - k));
            if (k == 1) chk("drain.stall", 32'(stall_req), 32'd0);
        end
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        step();
        chk("drain.done.rw", 32'(RegWrite), 32'd0);

        // Starvation: one queued entry loses to wb for regs 1..6
        for (int k = 1; k <= 6; k++) begin
            drive(1'b1, 5'(k), 32'h100 + 32'(k), (k == 1), 5'd20, 32'h2020, 1'b0, 5'd0);
            step();
            chk_write($sformatf("starve.wb%0d", k), 5'(k), 32'h100 + 32'(k));
            chk($sformatf("starve.cnt%0d", k), 32'(fifo_count), 32'd1);
            chk($sformatf("starve.stall%0d", k), 32'(stall_req), (k >= 5) ? 32'd1 : 32'd0);
        end
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        step();
        chk_write("bubble.head", 5'd20, 32'h2020);
        chk("bubble.cnt", 32'(fifo_count), 32'd0);
        step();
        chk("bubble.stall", 32'(stall_req), 32'd0);
        chk("bubble.rw",    32'(RegWrite),  32'd0);

        // Reset with three entries queued and a busy bit pending
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 5'd1, 32'h1, 1'b1, 5'(21 + k), 32'hC0 + 32'(k), (k == 0), 5'd21);
            step();
        end
        chk("pre.cnt",  32'(fifo_count), 32'd3);
        chk("pre.busy", busy,            32'h0020_0000);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        rst = 1'b1;
        step();
        chk("mrst.ready", 32'(mc_ready),   32'd0);
        chk("mrst.cnt",   32'(fifo_count), 32'd0);
        chk("mrst.busy",  busy,            32'd0);
        chk("mrst.rw",    32'(RegWrite),   32'd0);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("post.rw%0d", k), 32'(RegWrite), 32'd0);
        end
        chk("post.cnt", 32'(fifo_count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Write-side master for the 32x32 register file: the only driver of RdAddr/RdData/RegWrite.
- Merges two result sources into the single RF write port: the in-order pipeline writeback, which is always accepted, and a multi-cycle unit (mul/div), which is buffered in a small FIFO through a valid/ready handshake.
- Keeps a busy scoreboard of registers awaiting multi-cycle results, for the hazard unit.
- Raises a stall request when the FIFO is starved.

Parameters:
FIFO_DEPTH, 4, multi-cycle result FIFO entries (power of 2, >=2)
STARVE_LIMIT, 3, consecutive unserved cycles before stall_req asserts

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  synchronous active-high reset
wb_valid  in  1  pipeline writeback request this cycle
wb_addr  in  5  pipeline destination register
wb_data  in  32  pipeline result
mc_valid  in  1  multi-cycle result offered
mc_ready  out  1  FIFO can accept (count < FIFO_DEPTH)
mc_addr  in  5  multi-cycle destination register
mc_data  in  32  multi-cycle result
mc_issue  in  1  multi-cycle op dispatched this cycle
mc_issue_addr  in  5  its destination register
RdAddr  out  5  RF write address
RdData  out  32  RF write data
RegWrite  out  1  RF write enable
busy  out  32  scoreboard, bit i = register i awaits a multi-cycle result
stall_req  out  1  ask pipeline to insert a writeback bubble
fifo_count  out  3  current FIFO occupancy (0..FIFO_DEPTH)

Behaviour:
- Reset, while rst is high at a posedge:
  - RegWrite=0, RdAddr=0, RdData=0.
  - FIFO emptied, fifo_count=0, busy=0, stall_req=0, starve counter=0.
  - mc_ready is forced 0 while rst is high.
- Reset mid-operation discards all FIFO entries and busy bits; no pending write is issued afterwards.
- Output timing:
  - RdAddr/RdData/RegWrite are registered and change only on posedge.
  - The RF captures them on the following negedge.
  - Latency is one cycle from accepted request or FIFO pop to RegWrite=1.
- Arbitration, evaluated each cycle:
  - Priority 1: wb_valid && wb_addr!=0 issues the wb write.
  - Priority 2: otherwise, if the FIFO is non-empty, pop the head and issue it.
  - Otherwise the next cycle has RegWrite=0; RdAddr/RdData hold their previous values.
- Address 0:
  - A wb request to address 0 is ignored and never produces RegWrite=1.
  - A FIFO entry with address 0 is popped in its turn with RegWrite=0.
  - busy[0] is always 0.
- Pipeline writeback is never dropped or delayed, including while stall_req=1.
- Handshake and FIFO:
  - Push occurs when mc_valid && mc_ready at posedge.
  - mc_ready = !rst && fifo_count<FIFO_DEPTH, combinational from the registered count only. When full, a same-cycle pop does not enable a push.
  - Simultaneous push and pop when not full leaves fifo_count unchanged.
  - A pop from an empty FIFO never happens; a same-cycle push is not bypassed to the output.
  - Read/write pointers wrap modulo FIFO_DEPTH.
  - FIFO order is preserved.
- Scoreboard:
  - mc_issue with mc_issue_addr=i, i!=0, sets busy[i] at posedge.
  - busy[a] clears at the posedge where the FIFO entry for a is issued, i.e. the same edge RegWrite rises for it.
  - If set and clear of the same bit coincide, set wins.
  - A second mc_issue to an already-busy register is illegal; the hazard unit guarantees it never occurs.
  - A wb write to a busy register is not checked; the later write wins.
- Starvation:
  - The counter increments each cycle the FIFO is non-empty and wb wins; it saturates at STARVE_LIMIT.
  - It clears on any FIFO pop or when the FIFO is empty.
  - stall_req is a registered copy of (counter==STARVE_LIMIT).
  - stall_req drops the cycle after the head is popped.

Test Plan:
- Reset and idle: assert rst 2 cycles with mc_valid=1 -> RegWrite=0, mc_ready=0, busy=0, fifo_count=0. After release, mc_ready=1 and no push occurred during reset.
- Pipeline write: wb_valid=1, wb_addr=8, wb_data=0xDEADBEEF -> next cycle RegWrite=1, RdAddr=8, RdData=0xDEADBEEF. Then wb_addr=0 -> RegWrite=0.
- Multi-cycle path: mc_issue addr 5 -> busy[5]=1. Push {5,0x12345678} with wb idle -> RegWrite=1, RdAddr=5 one cycle after the push is popped; busy[5]=0 on that edge.
- Full FIFO: push 4 entries with wb_valid held high -> fifo_count=4, mc_ready=0, a 5th mc_valid is not accepted. Drop wb -> entries issue in push order on 4 consecutive cycles.
- Starvation: FIFO holds 1 entry, wb_valid=1 continuously to regs 1..6 -> stall_req=1 after 3 starved cycles plus 1 registered cycle, and every wb is written. One wb bubble -> FIFO head issues, stall_req=0 next cycle.
- Corner cases: mc_issue set and FIFO clear for reg 9 on the same cycle -> busy[9]=1. Assert rst with 3 entries queued -> no further RegWrite, fifo_count=0.
